// File: rtl/m_port_ultra_defs.sv
// rtl/m_port_ultra_defs.sv - constants shared by the point loader and the quickhull processor
package m_port_ultra_defs;
   localparam int PTSIZE  = 16;
   localparam int MAX_PTS = 255;
   localparam int NSLOTS  = 256;
   localparam int BUS_W   = NSLOTS * PTSIZE;

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   typedef logic [PTSIZE-1:0] point_t;
endpackage

// File: rtl/m_port_ultra_xrange_tracker.sv
// rtl/m_port_ultra_xrange_tracker.sv - running min/max x value and first-occurrence index
module m_port_ultra_xrange_tracker
   import m_port_ultra_defs::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear,
   input  logic       i_en,
   input  logic       i_first,
   input  logic [7:0] i_x,
   input  logic [7:0] i_idx,
   output logic [7:0] o_xmin_idx,
   output logic [7:0] o_xmax_idx
);
   logic [7:0] r_xmin;
   logic [7:0] r_xmax;
   logic [7:0] r_xmin_idx;
   logic [7:0] r_xmax_idx;

   // Strict compares: a tie never displaces the earlier index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_xmin     <= '0;
         r_xmax     <= '0;
         r_xmin_idx <= '0;
         r_xmax_idx <= '0;
      end else if (i_clear) begin
         r_xmin     <= '0;
         r_xmax     <= '0;
         r_xmin_idx <= '0;
         r_xmax_idx <= '0;
      end else if (i_en) begin
         if (i_first) begin
            r_xmin     <= i_x;
            r_xmax     <= i_x;
            r_xmin_idx <= i_idx;
            r_xmax_idx <= i_idx;
         end else begin
            if (i_x < r_xmin) begin
               r_xmin     <= i_x;
               r_xmin_idx <= i_idx;
            end
            if (i_x > r_xmax) begin
               r_xmax     <= i_x;
               r_xmax_idx <= i_idx;
            end
         end
      end
   end

   assign o_xmin_idx = r_xmin_idx;
   assign o_xmax_idx = r_xmax_idx;
endmodule

// File: rtl/m_port_ultra_point_loader.sv
// rtl/m_port_ultra_point_loader.sv - packs a streamed (x,y) frame into the flat hull point bus
module m_port_ultra_point_loader
   import m_port_ultra_defs::*;
(
   input  logic             CLK100MHZ,
   input  logic             CPU_RESET,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_x,
   input  logic [7:0]       in_y,
   input  logic             in_last,
   output logic [BUS_W-1:0] points,
   output logic [7:0]       SS,
   output logic             set_valid,
   input  logic             set_ack,
   output logic [7:0]       xmin_idx,
   output logic [7:0]       xmax_idx,
   output logic             overflow,
   output logic             degenerate
);
   localparam logic [7:0] MAX_SS = 8'(MAX_PTS);

   logic [0:0]       r_state;
   logic [BUS_W-1:0] r_points;
   logic [7:0]       r_ss;
   logic             r_overflow;
   point_t           r_last_pt;

   point_t      w_pt;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_dup;
   logic        w_store;
   logic        w_drop;
   logic        w_clear;
   logic [11:0] w_slot_base;

   assign w_pt       = {in_y, in_x};
   assign w_in_ready = (r_state == ST_FILL) && !CPU_RESET;
   assign w_accept   = in_valid && w_in_ready;
   // The first point of a frame has nothing to repeat.
   assign w_dup      = (r_ss != 8'd0) && (w_pt == r_last_pt);
   assign w_store    = w_accept && !w_dup && (r_ss != MAX_SS);
   assign w_drop     = w_accept && !w_dup && (r_ss == MAX_SS);
   assign w_clear    = (r_state == ST_HOLD) && set_ack;
   assign w_slot_base = {r_ss, 4'b0000};

   always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
      if (CPU_RESET) begin
         r_state    <= ST_FILL;
         r_points   <= '0;
         r_ss       <= '0;
         r_overflow <= 1'b0;
         r_last_pt  <= '0;
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_store) begin
                  r_points[w_slot_base +: PTSIZE] <= w_pt;
                  r_ss      <= r_ss + 8'd1;
                  r_last_pt <= w_pt;
               end
               if (w_drop) begin
                  r_overflow <= 1'b1;
               end
               if (w_accept && in_last) begin
                  r_state <= ST_HOLD;
               end
            end
            default: begin
               if (set_ack) begin
                  r_state    <= ST_FILL;
                  r_points   <= '0;
                  r_ss       <= '0;
                  r_overflow <= 1'b0;
                  r_last_pt  <= '0;
               end
            end
         endcase
      end
   end

   m_port_ultra_xrange_tracker u_xrange (
      .clk        (CLK100MHZ),
      .rst        (CPU_RESET),
      .i_clear    (w_clear),
      .i_en       (w_store),
      .i_first    (r_ss == 8'd0),
      .i_x        (in_x),
      .i_idx      (r_ss),
      .o_xmin_idx (xmin_idx),
      .o_xmax_idx (xmax_idx)
   );

   assign in_ready   = w_in_ready;
   assign points     = r_points;
   assign SS         = r_ss;
   assign set_valid  = (r_state == ST_HOLD);
   assign overflow   = r_overflow;
   // Only reported with a held set, so reset and FILL present 0.
   assign degenerate = (r_state == ST_HOLD) && (r_ss < 8'd3);
endmodule

// File: tb/tb_m_port_ultra_point_loader.sv
// tb/tb_m_port_ultra_point_loader.sv - scoreboard bench for the quickhull point loader
module tb_m_port_ultra_point_loader;
   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_x;
   logic [7:0]    in_y;
   logic          in_last;
   logic [4095:0] points;
   logic [7:0]    SS;
   logic          set_valid;
   logic          set_ack;
   logic [7:0]    xmin_idx;
   logic [7:0]    xmax_idx;
   logic          overflow;
   logic          degenerate;

   typedef struct {
      logic [7:0]    ss;
      logic [7:0]    xmin;
      logic [7:0]    xmax;
      logic          ovf;
      logic          deg;
      logic [4095:0] bus;
   } exp_t;

   exp_t sb[$];
   int   errs;
   int   checks;
   int   n_sets;

   m_port_ultra_point_loader dut (
      .CLK100MHZ  (clk),
      .CPU_RESET  (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_last    (in_last),
      .points     (points),
      .SS         (SS),
      .set_valid  (set_valid),
      .set_ack    (set_ack),
      .xmin_idx   (xmin_idx),
      .xmax_idx   (xmax_idx),
      .overflow   (overflow),
      .degenerate (degenerate)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_bus(input string nm, input logic [4095:0] act, input logic [4095:0] exp);
      int first_bad;
      logic [15:0] a;
      logic [15:0] e;
      checks++;
      if (act !== exp) begin
         errs++;
         first_bad = 0;
         for (int k = 255; k >= 0; k--) begin
            if (act[k*16 +: 16] !== exp[k*16 +: 16]) first_bad = k;
         end
         a = act[first_bad*16 +: 16];
         e = exp[first_bad*16 +: 16];
         $display("FAIL %s: slot %0d got %h expected %h", nm, first_bad, a, e);
      end
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic last, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      in_x = x;
      in_y = y;
      in_last = last;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic after_last();
      chk("latency_set_valid", 32'(set_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_set(input int target);
      int n;
      n = 0;
      while (n_sets < target && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("set_seen", 32'(n_sets >= target), 32'd1);
   endtask

   task automatic do_ack();
      @(negedge clk);
      set_ack = 1'b1;
      @(posedge clk);
      #1;
      set_ack = 1'b0;
      chk("ack_in_ready", 32'(in_ready), 32'd1);
      chk("ack_set_valid", 32'(set_valid), 32'd0);
      chk("ack_ss", 32'(SS), 32'd0);
      chk("ack_xmin", 32'(xmin_idx), 32'd0);
      chk("ack_xmax", 32'(xmax_idx), 32'd0);
      chk("ack_ovf", 32'(overflow), 32'd0);
      chk_bus("ack_points", points, '0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_set_valid"}, 32'(set_valid), 32'd0);
      chk({tag, "_ss"}, 32'(SS), 32'd0);
      chk({tag, "_xmin"}, 32'(xmin_idx), 32'd0);
      chk({tag, "_xmax"}, 32'(xmax_idx), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
      chk({tag, "_degen"}, 32'(degenerate), 32'd0);
      chk_bus({tag, "_points"}, points, '0);
   endtask

   initial begin
      exp_t e;
      int   bad;
      logic seen;
      errs = 0;
      checks = 0;
      n_sets = 0;
      rst = 1'b0;
      in_valid = 1'b0;
      in_x = '0;
      in_y = '0;
      in_last = 1'b0;
      set_ack = 1'b0;

      fork
         begin
            seen = 1'b0;
            forever begin
               @(negedge clk);
               if (rst || !set_valid) begin
                  seen = 1'b0;
               end else if (!seen) begin
                  seen = 1'b1;
                  if (sb.size() == 0) begin
                     chk("unexpected_set", 32'(sb.size()), 32'd1);
                  end else begin
                     e = sb.pop_front();
                     chk("sb_ss", 32'(SS), 32'(e.ss));
                     chk("sb_xmin", 32'(xmin_idx), 32'(e.xmin));
                     chk("sb_xmax", 32'(xmax_idx), 32'(e.xmax));
                     chk("sb_ovf", 32'(overflow), 32'(e.ovf));
                     chk("sb_degen", 32'(degenerate), 32'(e.deg));
                     chk_bus("sb_points", points, e.bus);
                  end
                  n_sets++;
               end
            end
         end
      join_none

      #1 rst = 1'b1;
      #5;
      chk_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_reset_in_ready", 32'(in_ready), 32'd1);

      // set_ack outside HOLD must be ignored
      @(negedge clk);
      set_ack = 1'b1;
      @(posedge clk);
      #1;
      set_ack = 1'b0;
      chk("fill_ack_in_ready", 32'(in_ready), 32'd1);

      e.ss = 8'd3; e.xmin = 8'd2; e.xmax = 8'd1; e.ovf = 1'b0; e.deg = 1'b0;
      e.bus = '0;
      e.bus[47:0] = 48'h0903_07C8_050A;
      sb.push_back(e);
      send(8'd10, 8'd5, 1'b0, 0);
      send(8'd200, 8'd7, 1'b0, 0);
      send(8'd3, 8'd9, 1'b1, 0);
      after_last();
      wait_set(1);

      in_valid = 1'b1;
      in_x = 8'd77;
      in_y = 8'd66;
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (SS !== 8'd3 || in_ready !== 1'b0 || set_valid !== 1'b1 ||
             points[47:0] !== 48'h0903_07C8_050A || points[4095:48] !== '0 ||
             xmin_idx !== 8'd2 || xmax_idx !== 8'd1)
            bad++;
      end
      in_valid = 1'b0;
      chk("hold_50_bad_cycles", 32'(bad), 32'd0);
      do_ack();

      e.ss = 8'd2; e.xmin = 8'd0; e.xmax = 8'd1; e.ovf = 1'b0; e.deg = 1'b1;
      e.bus = '0;
      e.bus[31:0] = 32'h0109_0404;
      sb.push_back(e);
      send(8'd4, 8'd4, 1'b0, 0);
      send(8'd4, 8'd4, 1'b0, 0);
      send(8'd4, 8'd4, 1'b0, 0);
      send(8'd9, 8'd1, 1'b1, 0);
      after_last();
      wait_set(2);
      do_ack();

      e.ss = 8'd3; e.xmin = 8'd0; e.xmax = 8'd0; e.ovf = 1'b0; e.deg = 1'b0;
      e.bus = '0;
      e.bus[47:0] = 48'h0307_0207_0107;
      sb.push_back(e);
      send(8'd7, 8'd1, 1'b0, 2);
      send(8'd7, 8'd2, 1'b0, 3);
      send(8'd7, 8'd3, 1'b1, 1);
      after_last();
      wait_set(3);
      do_ack();

      e.ss = 8'd255; e.xmin = 8'd0; e.xmax = 8'd254; e.ovf = 1'b1; e.deg = 1'b0;
      e.bus = '0;
      for (int k = 0; k < 255; k++) e.bus[k*16 +: 16] = {8'h00, 8'(k)};
      sb.push_back(e);
      for (int i = 0; i < 300; i++) begin
         send(8'(i), 8'(i >> 8), (i == 299), 0);
      end
      after_last();
      chk("ovf_top_slot", 32'(points[4095:4080]), 32'd0);
      wait_set(4);
      do_ack();

      send(8'd1, 8'd1, 1'b0, 0);
      send(8'd2, 8'd2, 1'b0, 0);
      send(8'd3, 8'd3, 1'b0, 0);
      send(8'd9, 8'd9, 1'b0, 0);
      chk("pre_reset_xmax", 32'(xmax_idx), 32'd3);
      in_x = 8'd5;
      in_y = 8'd5;
      in_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk_reset_outputs("midframe");
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midframe_release_in_ready", 32'(in_ready), 32'd1);

      e.ss = 8'd3; e.xmin = 8'd1; e.xmax = 8'd2; e.ovf = 1'b0; e.deg = 1'b0;
      e.bus = '0;
      e.bus[47:0] = 48'h0350_0214_0132;
      sb.push_back(e);
      send(8'd50, 8'd1, 1'b0, 0);
      send(8'd20, 8'd2, 1'b0, 0);
      send(8'd80, 8'd3, 1'b1, 0);
      after_last();
      wait_set(5);
      do_ack();

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
